prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Producer side of the processor's 32-bit instruction-register format: encodes instruction fields into IR words and writes them sequentially into the processor instruction memory.
- Holds the processor in reset while a program is loaded.
- Pads unused instruction slots with jump-to-self words so the core parks safely.
- Sits between the bench or host stimulus and `top`; replaces hierarchical poking of instruction memory.

Parameters:
- ADDR_W, 4, instruction memory address width.
- DEPTH, 16, number of instruction words loaded per session; DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load session; sampled only in IDLE.
- fld_valid  in  1  instruction fields valid.
- fld_ready  out  1  loader accepts fields this cycle.
- fld_last  in  1  accompanying instruction is the last of the program.
- oper_type  in  5  opcode, IR[31:27].
- rdst  in  5  destination register, IR[26:22].
- rsrc1  in  5  source 1, IR[21:17].
- imm_mode  in  1  immediate select, IR[16].
- rsrc2  in  5  source 2, IR[15:11]; used only when imm_mode=0.
- isrc  in  16  immediate, IR[15:0]; used only when imm_mode=1.
- im_we  out  1  instruction memory write strobe.
- im_addr  out  ADDR_W  write address.
- im_wdata  out  32  encoded IR word.
- cpu_hold  out  1  drives processor sys_rst; 1 = core held.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse when a program is committed.
- err  out  1  sticky illegal-opcode flag, cleared by next start.
- count  out  ADDR_W+1  user instructions written this session.

Behaviour:
- Reset values (async, immediate): state IDLE, cpu_hold=1, im_we=0, im_addr=0, im_wdata=0, fld_ready=0, busy=0, done=0, err=0, count=0.
- Encoding, imm_mode=1: {oper_type, rdst, rsrc1, 1'b1, isrc}.
- Encoding, imm_mode=0: {oper_type, rdst, rsrc1, 1'b0, rsrc2, 11'b0}; isrc is ignored.
- Legal opcodes: 00000-01011, 01101, 01110, 01111, 10001, 10010-11010.
- Illegal opcodes: 01100, 10000, 11011-11111.
- IDLE:
  - fld_ready=0.
  - start=1 -> ACCEPT. On that transition: cpu_hold=1, busy=1, im_addr=0, count=0, err=0.
  - A new session reasserts cpu_hold even after an earlier program has been released.
- ACCEPT:
  - fld_ready=1.
  - On fld_valid&fld_ready with a legal opcode: register the encoded word -> WRITE.
  - On handshake with an illegal opcode: err=1, nothing written -> IDLE. busy=0, cpu_hold stays 1, no done pulse.
- WRITE:
  - im_we=1 for exactly one cycle at im_addr; fld_ready=0.
  - Latency: handshake at cycle N -> im_we high in cycle N+1. Peak throughput is one instruction per 2 cycles.
  - After the write: count+1.
  - If the word was last, or im_addr==DEPTH-1: the word counts as last. Next address is im_addr+1; go to PAD, or RELEASE if im_addr==DEPTH-1.
  - Otherwise: im_addr+1 -> ACCEPT.
  - Overflow: the DEPTH-th accepted word ends the session even when fld_last=0.
- PAD:
  - One write per cycle of {10010, 5'b0, 5'b0, 1'b1, 16'(im_addr)}, i.e. jump to own address.
  - im_addr increments each cycle; after writing DEPTH-1 -> RELEASE.
  - count is not incremented.
- RELEASE (one cycle): cpu_hold=0, done=1, busy=0 -> IDLE. cpu_hold stays 0 in IDLE until the next start.
- start in any state other than IDLE is ignored.
- fld_valid outside ACCEPT is ignored; fields are not buffered.
- sys_rst mid-session: immediate abort to reset values. A partially written memory is left as is; cpu_hold=1 guards it.

Test Plan:
- Immediate encode: start; single field ADD (op=00010, rdst=2, rsrc1=0, imm_mode=1, isrc=5, fld_last=1) -> im_we at addr 0 with 0x10810005. Then pad writes 0x90010001..0x9001000F at addrs 1-15, done pulse, cpu_hold 1->0, count=1.
- Register encode: SUB (op=00011, rdst=3, rsrc1=1, imm_mode=0, rsrc2=2, isrc=0xFFFF) -> 0x18C21000. The isrc field is ignored.
- Multi-word with valid gaps: 3 instructions with 0-2 idle cycles between valids -> writes at addrs 0,1,2 in order. Each im_we lands one cycle after its handshake; first pad is 0x90010003; count=3.
- Illegal opcode: second instruction op=01100 -> err=1, addr 1 never written, no done, cpu_hold stays 1, busy=0. A following start clears err.
- Overflow: 16 legal words, none with fld_last -> 16 writes at addrs 0-15, no PAD writes, done pulse, count=16. A 17th fld_valid sees fld_ready=0.
- Reset mid-session: assert sys_rst during the third WRITE cycle -> all outputs return to reset values immediately (cpu_hold=1, im_we=0). A subsequent start reloads correctly from addr 0.

Source files
------------

// File: rtl/prog_loader_if.sv
// Instruction-field channel from the host/bench into the program loader.
// The host (master) presents encoded-field requests; the loader (slave) accepts them.
interface prog_loader_if;
  logic        fld_valid;
  logic        fld_ready;
  logic        fld_last;
  logic [4:0]  oper_type;
  logic [4:0]  rdst;
  logic [4:0]  rsrc1;
  logic        imm_mode;
  logic [4:0]  rsrc2;
  logic [15:0] isrc;

  modport master (
    output fld_valid, fld_last, oper_type, rdst, rsrc1, imm_mode, rsrc2, isrc,
    input  fld_ready
  );

  modport slave (
    input  fld_valid, fld_last, oper_type, rdst, rsrc1, imm_mode, rsrc2, isrc,
    output fld_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Encodes instruction fields into 32-bit IR words and loads them into instruction memory,
// holding the core in reset and padding unused slots with jump-to-self words.
module prog_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  prog_loader_if.slave      fld,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {StIdle, StAccept, StWrite, StPad, StRelease} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       enc_word;
  logic [31:0]       pad_word;

  function automatic logic op_legal(input logic [4:0] op);
    return !(op == 5'b01100 || op == 5'b10000 || op >= 5'b11011);
  endfunction

  always_comb begin
    if (fld.imm_mode) begin
      enc_word = {fld.oper_type, fld.rdst, fld.rsrc1, 1'b1, fld.isrc};
    end else begin
      enc_word = {fld.oper_type, fld.rdst, fld.rsrc1, 1'b0, fld.rsrc2, 11'b0};
    end
  end

  // Jump-to-self: the core parks on any slot the program does not use.
  assign pad_word = {5'b10010, 5'b0, 5'b0, 1'b1, 16'(addr_q)};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    hold_d  = hold_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccept;
          hold_d  = 1'b1;
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StAccept: begin
        if (fld.fld_valid) begin
          if (op_legal(fld.oper_type)) begin
            wdata_d = enc_word;
            last_d  = fld.fld_last;
            state_d = StWrite;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StWrite: begin
        count_d = count_q + CountOne;
        addr_d  = addr_q + AddrOne;
        if (addr_q == LastAddr) begin
          state_d = StRelease;
        end else if (last_q) begin
          state_d = StPad;
        end else begin
          state_d = StAccept;
        end
      end
      StPad: begin
        addr_d = addr_q + AddrOne;
        if (addr_q == LastAddr) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Core is released in the same cycle that done pulses.
    if (state_d == StRelease) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      hold_q  <= 1'b1;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign fld.fld_ready = (state_q == StAccept);
  assign im_we         = (state_q == StWrite) || (state_q == StPad);
  assign im_addr       = addr_q;
  assign im_wdata      = (state_q == StPad) ? pad_word : wdata_q;
  assign cpu_hold      = hold_q;
  assign busy          = (state_q == StAccept) || (state_q == StWrite) || (state_q == StPad);
  assign done          = (state_q == StRelease);
  assign err           = err_q;
  assign count         = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven field vectors with a write scoreboard
// and hand-written sequences for illegal opcode, overflow and mid-session reset.
module tb_prog_loader;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              sys_rst;
  logic              start;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  prog_loader_if fld_bus ();

  prog_loader #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .start   (start),
    .fld     (fld_bus),
    .im_we   (im_we),
    .im_addr (im_addr),
    .im_wdata(im_wdata),
    .cpu_hold(cpu_hold),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .count   (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rdst;
    logic [4:0]  rs1;
    logic        imm;
    logic [4:0]  rs2;
    logic [15:0] isrc;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  vec_t vecs[4];
  vec_t bad_vec;
  exp_t sb_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   done_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int addr, input logic [31:0] data);
    exp_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic push_pads(input int from);
    for (int a = from; a < int'(DEPTH); a++) push_exp(a, 32'h9001_0000 | 32'(a));
  endtask

  // Scoreboard: every write must match the next expected (addr, data).
  always @(negedge clk) begin
    exp_t e;
    if (!sys_rst) begin
      if (done) done_cnt++;
      if (im_we) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h@%h required=none", im_wdata, im_addr);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", 32'(im_addr), 32'(e.addr));
          chk("wr_data", im_wdata, e.data);
        end
      end
    end
  end

  task automatic start_session();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    chk("start_count", 32'(count), 32'd0);
    chk("start_err", 32'(err), 32'd0);
    chk("start_ready", 32'(fld_bus.fld_ready), 32'd1);
  endtask

  task automatic send(input vec_t v, input logic last, input int gap, input bit expect_write);
    int n;
    repeat (gap) @(negedge clk);
    fld_bus.oper_type = v.op;
    fld_bus.rdst      = v.rdst;
    fld_bus.rsrc1     = v.rs1;
    fld_bus.imm_mode  = v.imm;
    fld_bus.rsrc2     = v.rs2;
    fld_bus.isrc      = v.isrc;
    fld_bus.fld_last  = last;
    fld_bus.fld_valid = 1'b1;
    n = 0;
    while (fld_bus.fld_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++;
      failures++;
      $display("FAIL hs_timeout actual_ready=%b required=1", fld_bus.fld_ready);
      fld_bus.fld_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 fld_bus.fld_valid = 1'b0;
      if (expect_write) begin
        @(negedge clk);
        chk("latency_we", 32'(im_we), 32'd1);
      end
    end
  endtask

  task automatic wait_done(input int exp_count);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n == 60) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%b required=1", done);
    end else begin
      chk("rel_hold", 32'(cpu_hold), 32'd0);
      chk("rel_busy", 32'(busy), 32'd0);
      chk("rel_count", 32'(count), 32'(exp_count));
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("idle_hold", 32'(cpu_hold), 32'd0);
    end
  endtask

  initial begin
    int d;
    vecs[0] = '{5'b00010, 5'd2,  5'd0,  1'b1, 5'd0,  16'h0005, 32'h1081_0005};
    vecs[1] = '{5'b00011, 5'd3,  5'd1,  1'b0, 5'd2,  16'hFFFF, 32'h18C2_1000};
    vecs[2] = '{5'b01111, 5'd31, 5'd31, 1'b1, 5'd0,  16'hA5A5, 32'h7FFF_A5A5};
    vecs[3] = '{5'b11010, 5'd0,  5'd5,  1'b0, 5'd31, 16'h1234, 32'hD00A_F800};
    bad_vec = '{5'b01100, 5'd1,  5'd2,  1'b1, 5'd0,  16'h0001, 32'h0};

    sys_rst = 1'b1;
    start   = 1'b0;
    fld_bus.fld_valid = 1'b0;
    fld_bus.fld_last  = 1'b0;
    fld_bus.oper_type = '0;
    fld_bus.rdst      = '0;
    fld_bus.rsrc1     = '0;
    fld_bus.imm_mode  = 1'b0;
    fld_bus.rsrc2     = '0;
    fld_bus.isrc      = '0;

    repeat (2) @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_we", 32'(im_we), 32'd0);
    chk("rst_addr", 32'(im_addr), 32'd0);
    chk("rst_wdata", im_wdata, 32'd0);
    chk("rst_ready", 32'(fld_bus.fld_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    sys_rst = 1'b0;

    // Single immediate-form word, then jump-to-self padding.
    start_session();
    push_exp(0, vecs[0].word);
    push_pads(1);
    send(vecs[0], 1'b1, 0, 1'b1);
    wait_done(1);

    // Register form: isrc must be ignored.
    start_session();
    push_exp(0, vecs[1].word);
    push_pads(1);
    send(vecs[1], 1'b1, 0, 1'b1);
    wait_done(1);

    // Three words with 0..2 idle cycles between valids.
    start_session();
    for (int i = 0; i < 3; i++) begin
      push_exp(i, vecs[i+1].word);
      if (i == 2) push_pads(3);
      send(vecs[i+1], (i == 2), i, 1'b1);
    end
    wait_done(3);

    // Illegal opcode on the second word aborts the session.
    start_session();
    push_exp(0, vecs[0].word);
    send(vecs[0], 1'b0, 0, 1'b1);
    d = done_cnt;
    send(bad_vec, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_hold", 32'(cpu_hold), 32'd1);
    chk("ill_we", 32'(im_we), 32'd0);
    repeat (5) @(negedge clk);
    chk("ill_no_done", 32'(done_cnt), 32'(d));
    chk("ill_hold_kept", 32'(cpu_hold), 32'd1);
    chk("ill_err_sticky", 32'(err), 32'd1);

    // Overflow: DEPTH words without fld_last fill memory, no padding.
    start_session();
    for (int i = 0; i < int'(DEPTH); i++) begin
      push_exp(i, vecs[i % 4].word);
      send(vecs[i % 4], 1'b0, 0, 1'b1);
    end
    wait_done(int'(DEPTH));
    fld_bus.fld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ovf_ready_low", 32'(fld_bus.fld_ready), 32'd0);
    end
    fld_bus.fld_valid = 1'b0;

    // Reset during the third WRITE cycle, then a clean reload.
    start_session();
    for (int i = 0; i < 2; i++) begin
      push_exp(i, vecs[i].word);
      send(vecs[i], 1'b0, 0, 1'b1);
    end
    send(vecs[2], 1'b0, 0, 1'b0);
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_we", 32'(im_we), 32'd0);
    chk("mid_rst_addr", 32'(im_addr), 32'd0);
    chk("mid_rst_wdata", im_wdata, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ready", 32'(fld_bus.fld_ready), 32'd0);
    sb_q.delete();
    @(negedge clk);
    sys_rst = 1'b0;
    start_session();
    push_exp(0, vecs[3].word);
    push_pads(1);
    send(vecs[3], 1'b1, 0, 1'b1);
    wait_done(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 0);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
